// File: rtl/data_extender.sv
// Width-expansion stage: re-aligns narrow words into a wide word, behind a
// registered 2-entry skid buffer with a debug transfer counter.
module data_extender #(
  parameter string EXTENSION_MODE    = "MSB",
  parameter bit    SIGNED_EXT        = 1'b1,
  parameter int    DATA_IN_BITWIDTH  = 16,
  parameter int    DATA_OUT_BITWIDTH = 32,
  parameter int    COUNT_BITWIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_IN_BITWIDTH-1:0]  data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_OUT_BITWIDTH-1:0] data_out,
  input  logic                         count_clear,
  output logic [COUNT_BITWIDTH-1:0]    xfer_count
);

  // state | meaning
  // EMPTY | no word buffered
  // ONE   | head holds a word, skid free
  // FULL  | head and skid both hold words; input stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam int D = DATA_OUT_BITWIDTH - DATA_IN_BITWIDTH;

  state_t                         state;
  logic [DATA_OUT_BITWIDTH-1:0]   head;
  logic [DATA_OUT_BITWIDTH-1:0]   skid;
  logic [DATA_OUT_BITWIDTH-1:0]   conv;
  logic [COUNT_BITWIDTH-1:0]      count;
  logic                           push;
  logic                           pop;

  generate
    if (EXTENSION_MODE != "MSB" && EXTENSION_MODE != "LSB") begin : g_bad_mode
      $error("data_extender: EXTENSION_MODE must be \"MSB\" or \"LSB\"");
    end
    if (DATA_IN_BITWIDTH < 1 || D < 0) begin : g_bad_width
      $error("data_extender: need 1 <= DATA_IN_BITWIDTH <= DATA_OUT_BITWIDTH");
    end

    if (D <= 0) begin : g_pass
      assign conv = data_in[DATA_OUT_BITWIDTH-1:0];
    end else if (EXTENSION_MODE == "LSB") begin : g_lsb
      assign conv = {data_in, {D{1'b0}}};
    end else if (SIGNED_EXT) begin : g_sext
      assign conv = {{D{data_in[DATA_IN_BITWIDTH-1]}}, data_in};
    end else begin : g_zext
      assign conv = {{D{1'b0}}, data_in};
    end
  endgenerate

  // Gating with reset keeps handshakes out of reset cycles while the
  // port still depends only on registered state, never on out_ready.
  assign in_ready   = (state != FULL) && !reset;
  assign out_valid  = (state != EMPTY);
  assign data_out   = head;
  assign xfer_count = count;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= conv;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid  <= conv;
            state <= FULL;
          end else if (pop && !push) begin
            state <= EMPTY;
          end else if (push && pop) begin
            head <= conv;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase

      if (count_clear)
        count <= '0;
      else if (pop)
        count <= count + COUNT_BITWIDTH'(1);
    end
  end

endmodule
